// File: rtl/mc_capture_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mc_capture_pkg
// Purpose  : Shared types, CSR map and STATUS layout for the result capture.
// Revision : 1.0
// ============================================================================
package mc_capture_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SKIP    = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_e;

    localparam int CTRL_ADDR  = 0;
    localparam int DEPTH_ADDR = 1;

    localparam int START = 0;
    localparam int ABORT = 1;

    localparam int STAT_BUSY      = 0;
    localparam int STAT_DONE      = 1;
    localparam int STAT_COUNT_LSB = 8;
    localparam int STAT_COUNT_W   = 8;

    localparam int COUNT_W = 9;

    function automatic logic [31:0] pack_status(
        input logic               busy,
        input logic               done,
        input logic [COUNT_W-1:0] count
    );
        logic [31:0] s;
        s                                   = '0;
        s[STAT_BUSY]                        = busy;
        s[STAT_DONE]                        = done;
        s[STAT_COUNT_LSB +: STAT_COUNT_W]   = count[STAT_COUNT_W-1:0];
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mc_capture_ram.sv
`default_nettype none
// ============================================================================
// Module   : mc_capture_ram
// Purpose  : DEPTH x WIDTH simple dual-port RAM, registered read-before-write.
// Revision : 1.0
// ============================================================================
module mc_capture_ram #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // No reset so the array and output register map onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem_q[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule
`default_nettype wire

// File: rtl/mc_result_capture.sv
`default_nettype none
// ============================================================================
// Module   : mc_result_capture
// Purpose  : Skips pipeline-fill cycles after start, captures DEPTH samples,
//            and exposes status and buffer over an Avalon-MM slave.
// Revision : 1.0
// ============================================================================
module mc_result_capture
    import mc_capture_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int SKIP   = 2
) (
    input  logic              div_clock,
    input  logic              reset_n,
    input  logic [WIDTH-1:0]  data_in,
    input  logic [ADDR_W:0]   avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [31:0]       avs_writedata,
    output logic [31:0]       avs_readdata,
    output logic              done_irq
);

    localparam logic [7:0]         SKIP_LAST   = 8'((SKIP > 0) ? SKIP - 1 : 0);
    localparam logic [COUNT_W-1:0] CNT_LAST    = COUNT_W'(DEPTH - 1);
    localparam logic [COUNT_W-1:0] CNT_FULL    = COUNT_W'(DEPTH);
    localparam state_e             START_STATE = (SKIP == 0) ? S_CAPTURE : S_SKIP;

    state_e             state_q,     state_d;
    logic [7:0]         skip_cnt_q,  skip_cnt_d;
    logic [ADDR_W-1:0]  wr_ptr_q,    wr_ptr_d;
    logic [COUNT_W-1:0] count_q,     count_d;
    logic               done_irq_q,  done_irq_d;
    logic [31:0]        csr_rdata_q, csr_rdata_d;
    logic               rd_buf_q,    rd_buf_d;

    logic               w_csr_sel;
    logic [ADDR_W-1:0]  w_word_addr;
    logic               w_ctrl_wr;
    logic               w_start;
    logic               w_abort;
    logic               w_busy;
    logic               w_ram_we;
    logic [31:0]        w_csr_rdata;
    logic [WIDTH-1:0]   w_ram_rdata;
    logic               w_unused_wdata;

    assign w_csr_sel      = ~avs_address[ADDR_W];
    assign w_word_addr    = avs_address[ADDR_W-1:0];
    assign w_ctrl_wr      = avs_write & w_csr_sel & (w_word_addr == ADDR_W'(CTRL_ADDR));
    // Abort dominates a simultaneous start.
    assign w_abort        = w_ctrl_wr & avs_writedata[ABORT];
    assign w_start        = w_ctrl_wr & avs_writedata[START] & ~avs_writedata[ABORT];
    assign w_busy         = (state_q == S_SKIP) | (state_q == S_CAPTURE);
    assign w_unused_wdata = ^avs_writedata[31:2];

    always_comb begin
        state_d    = state_q;
        skip_cnt_d = skip_cnt_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        w_ram_we   = 1'b0;
        done_irq_d = (state_q == S_DONE) & ~w_start & ~w_abort;

        if (w_abort) begin
            state_d = S_IDLE;
        end else if (w_start) begin
            state_d    = START_STATE;
            skip_cnt_d = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end else begin
            case (state_q)
                S_SKIP: begin
                    skip_cnt_d = skip_cnt_q + 8'd1;
                    if (skip_cnt_q == SKIP_LAST) begin
                        state_d = S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    w_ram_we = 1'b1;
                    wr_ptr_d = wr_ptr_q + ADDR_W'(1);
                    count_d  = (count_q == CNT_FULL) ? count_q : count_q + COUNT_W'(1);
                    if (count_q == CNT_LAST) begin
                        state_d = S_DONE;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    // CSR read mux sees pre-write state, so a same-cycle write is invisible.
    always_comb begin
        w_csr_rdata = '0;
        if (w_word_addr == ADDR_W'(CTRL_ADDR)) begin
            w_csr_rdata = pack_status(w_busy, done_irq_q, count_q);
        end else if (w_word_addr == ADDR_W'(DEPTH_ADDR)) begin
            w_csr_rdata = 32'(DEPTH);
        end
    end

    always_comb begin
        csr_rdata_d = csr_rdata_q;
        rd_buf_d    = rd_buf_q;
        if (avs_read) begin
            rd_buf_d = ~w_csr_sel;
            if (w_csr_sel) begin
                csr_rdata_d = w_csr_rdata;
            end
        end
    end

    always_ff @(posedge div_clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            skip_cnt_q  <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            done_irq_q  <= 1'b0;
            csr_rdata_q <= '0;
            rd_buf_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            skip_cnt_q  <= skip_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            done_irq_q  <= done_irq_d;
            csr_rdata_q <= csr_rdata_d;
            rd_buf_q    <= rd_buf_d;
        end
    end

    mc_capture_ram #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (div_clock),
        .we    (w_ram_we),
        .waddr (wr_ptr_q),
        .wdata (data_in),
        .re    (avs_read & ~w_csr_sel),
        .raddr (w_word_addr),
        .rdata (w_ram_rdata)
    );

    assign avs_readdata = rd_buf_q ? 32'(w_ram_rdata) : csr_rdata_q;
    assign done_irq     = done_irq_q;

endmodule
`default_nettype wire

// File: doc/mc_result_capture.md
Name: mc_result_capture

Overview:
Single-clock capture buffer in the divided-clock domain. It sits directly downstream of the multi-cycle delay stage and takes that stage's registered data_out as its data_in. On an armed start it discards a fixed number of pipeline-fill cycles, then records DEPTH consecutive samples. The HPS reads the status and captured words back over a simple Avalon-MM slave.

Parameters:
WIDTH, 32, sample width; legal range 1..32.
DEPTH, 16, number of samples captured per run; power of two, 2..256.
ADDR_W, 4, log2(DEPTH).
SKIP, 2, cycles discarded after start before capture begins; legal range 0..255.

Ports:
div_clock  in  1  sole clock; the divided clock that the delay stage's output register runs on.
reset_n  in  1  asynchronous, active-low reset.
data_in  in  WIDTH  sample input, connected to the delay stage data_out.
avs_address  in  ADDR_W+1  MSB 0 selects CSR space, MSB 1 selects buffer word [ADDR_W-1:0].
avs_read  in  1  read strobe.
avs_write  in  1  write strobe.
avs_writedata  in  32  write data.
avs_readdata  out  32  read data, fixed read latency 1.
done_irq  out  1  level output, high while in DONE.

Behaviour:
- Reset values: state IDLE, wr_ptr 0, skip_cnt 0, count 0, avs_readdata 0, done_irq 0. Buffer RAM is not reset.
- CSR map (MSB 0):
  - addr 0 CTRL (write): bit0 start, bit1 abort.
  - addr 0 STATUS (read): bit0 busy (SKIP or CAPTURE), bit1 done, [15:8] count, other bits 0.
  - addr 1 read: DEPTH constant.
  - Other CSR addresses read 0; writes to them are ignored.
- States:
  - IDLE: waits for start.
  - SKIP: skip_cnt increments each cycle; moves to CAPTURE when skip_cnt == SKIP-1. With SKIP=0, start goes directly to CAPTURE.
  - CAPTURE: each cycle writes buf[wr_ptr] <= data_in, then wr_ptr++ and count++. After the write with count == DEPTH-1, moves to DONE.
  - DONE: done_irq=1, holds until start or abort.
- Start (write CTRL bit0=1), accepted in any state:
  - Clears count, wr_ptr, skip_cnt and done.
  - Enters SKIP (or CAPTURE) on the next edge.
  - Restarting mid-run discards the partial run; buffer contents are not cleared.
- Abort (bit1=1): next state IDLE, count retained, done cleared. If start and abort are both set, abort wins.
- Timing: the first captured sample is the data_in present SKIP+1 cycles after the edge that registers the write. The last sample is written SKIP+DEPTH cycles after that edge; done_irq rises on the following edge.
- Reads:
  - avs_readdata is registered one cycle after avs_read.
  - Buffer words are zero-extended to 32 bits.
  - Reading a word in the same cycle it is written returns the old value (read-before-write).
  - Reads are legal in any state.
  - Without avs_read, avs_readdata holds its previous value.
- Simultaneous avs_read and avs_write: both are serviced; the read returns pre-write CSR state.
- Wrap: wr_ptr never wraps within a run, because DONE is entered at count DEPTH. count is 9 bits internally and saturates at DEPTH; STATUS reports count[7:0].
- Asynchronous reset mid-run returns the block to IDLE immediately. Buffer contents are retained but undefined for verification.

Decomposition:
- Package mc_capture_pkg holds:
  - state enum {IDLE, SKIP, CAPTURE, DONE};
  - CSR address constants CTRL_ADDR=0 and DEPTH_ADDR=1;
  - CTRL bit indices START=0 and ABORT=1;
  - STATUS field positions.
- One natural sub-module: mc_capture_ram. It is a DEPTH x WIDTH simple dual-port RAM with one write port and one registered read port, read-before-write, inferable as M10K.

Test Plan:
- Reset then read STATUS -> 0x00000000; read addr 1 -> 0x00000010.
- Defaults, data_in = incrementing counter whose value at the start-write edge is 100; start -> buffer words 0..15 read 103..118, STATUS 0x00001002, done_irq high.
- Abort after 5 captured samples -> STATUS 0x00000500, done_irq 0; then start again -> full run completes with count 16.
- Start and abort in the same write (writedata 0x3) during CAPTURE -> state IDLE, busy 0.
- SKIP=0, WIDTH=8, data_in 0xA5 constant -> words read 0x000000A5; done_irq rises exactly DEPTH+1 cycles after the start write edge.
- reset_n pulsed low during SKIP -> STATUS 0, done_irq 0 asynchronously; next start runs normally.
